// File: rtl/polar_pkg.sv
// Shared constants and types for the screen <-> polar coordinate blocks.
// Tangent thresholds are in units of 1/64; divisors rescale a*64 to a radius.
package polar_pkg;

  localparam int CENTER_X_DEF = 399;
  localparam int CENTER_Y_DEF = 239;

  localparam int TAN_LO = 13;
  localparam int TAN_HI = 43;

  localparam logic [6:0] K_AXIS = 7'd64;
  localparam logic [6:0] K_MID  = 7'd59;
  localparam logic [6:0] K_DIAG = 7'd45;

  typedef logic [3:0] sector_t;

  typedef enum logic [1:0] {
    IDLE,
    CLASS,
    DIV,
    DONE
  } state_t;

  // Map a first-quadrant fine sector (0..4) into the full 16-sector circle.
  function automatic sector_t fold_sector(input sector_t f, input logic dx_neg, input logic dy_neg);
    sector_t s;
    case ({dx_neg, dy_neg})
      2'b00:   s = f;
      2'b10:   s = 4'd8 - f;
      2'b11:   s = 4'd8 + f;
      default: s = 4'd0 - f;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// 16-bit by 7-bit restoring divider, one quotient bit per step; 16 steps after load.
// o_quot_nxt is the quotient as it will stand after the current step is applied.
module seq_divider
  import polar_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [15:0] i_num,
  input  logic [6:0]  i_den,
  output logic [15:0] o_quot_nxt
);

  logic [15:0] r_num;
  logic [15:0] r_quot;
  logic [6:0]  r_rem;
  logic [6:0]  r_den;

  logic [7:0] w_rem_sh;
  logic [7:0] w_diff;
  logic       w_ge;

  assign w_rem_sh   = {r_rem, r_num[15]};
  assign w_ge       = w_rem_sh >= {1'b0, r_den};
  assign w_diff     = w_rem_sh - {1'b0, r_den};
  assign o_quot_nxt = {r_quot[14:0], w_ge};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_num  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_den  <= '0;
    end else if (i_load) begin
      r_num  <= i_num;
      r_quot <= '0;
      r_rem  <= '0;
      r_den  <= i_den;
    end else if (i_step) begin
      r_num  <= {r_num[14:0], 1'b0};
      r_quot <= o_quot_nxt;
      // Remainder stays below the divisor (<= 64), so 7 bits always hold it.
      r_rem  <= 7'(w_ge ? w_diff : w_rem_sh);
    end
  end

endmodule

// File: rtl/find_polar.sv
// Screen pixel -> (distance, angle) polar conversion, one request at a time.
// FIND_POLAR_SATURATE_EN: clamp radius above 511 and flag out_of_range.
module find_polar
  import polar_pkg::*;
#(
  parameter int CENTER_X = CENTER_X_DEF,
  parameter int CENTER_Y = CENTER_Y_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic       busy,
  output logic       done,
  output logic [8:0] distance,
  output logic [3:0] angle,
  output logic       out_of_range
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_a;
  logic [10:0] r_b;
  logic        r_xmaj;
  logic        r_dx_neg;
  logic        r_dy_neg;
  sector_t     r_sect;
  logic [3:0]  r_cnt;
  logic [8:0]  r_dist;
  sector_t     r_angle;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_adx;
  logic [10:0] w_ady;
  logic        w_xmaj;

  assign w_dx   = {1'b0, px} - 11'(CENTER_X);
  assign w_dy   = 11'(CENTER_Y) - {1'b0, py};
  assign w_adx  = w_dx[10] ? (11'd0 - w_dx) : w_dx;
  assign w_ady  = w_dy[10] ? (11'd0 - w_dy) : w_dy;
  assign w_xmaj = w_adx >= w_ady;

  logic [16:0] w_b64;
  logic [16:0] w_a_lo;
  logic [16:0] w_a_hi;
  sector_t     w_f;
  logic [6:0]  w_k;
  sector_t     w_angle;

  assign w_b64  = {r_b, 6'd0};
  assign w_a_lo = 17'(r_a) * 17'(TAN_LO);
  assign w_a_hi = 17'(r_a) * 17'(TAN_HI);

  // Centre pixel must land on sector 0 rather than fall through to the diagonal.
  always_comb begin
    w_f = 4'd2;
    if (r_a == 11'd0)        w_f = 4'd0;
    else if (w_b64 < w_a_lo) w_f = r_xmaj ? 4'd0 : 4'd4;
    else if (w_b64 < w_a_hi) w_f = r_xmaj ? 4'd1 : 4'd3;
  end

  always_comb begin
    case (w_f)
      4'd0, 4'd4: w_k = K_AXIS;
      4'd1, 4'd3: w_k = K_MID;
      default:    w_k = K_DIAG;
    endcase
  end

  assign w_angle = fold_sector(w_f, r_dx_neg, r_dy_neg);

  logic        w_div_load;
  logic        w_div_step;
  logic        w_out_we;
  logic [15:0] w_quot_nxt;
  logic [15:0] w_radius;
  sector_t     w_angle_out;

  seq_divider u_div (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_num      (16'({r_a, 6'd0})),
    .i_den      (w_k),
    .o_quot_nxt (w_quot_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    w_out_we    = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = CLASS;
      CLASS: begin
        w_div_load = 1'b1;
        if (w_k == K_AXIS) begin
          w_out_we    = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DIV;
        end
      end
      DIV: begin
        w_div_step = 1'b1;
        if (r_cnt == 4'd15) begin
          w_out_we    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_radius    = (r_state == CLASS) ? {5'd0, r_a} : w_quot_nxt;
  assign w_angle_out = (r_state == CLASS) ? w_angle : r_sect;

  logic [8:0] w_dist;
`ifdef FIND_POLAR_SATURATE_EN
  logic w_oor;
  logic r_oor;
  assign w_oor  = w_radius > 16'd511;
  assign w_dist = w_oor ? 9'd511 : w_radius[8:0];

  always_ff @(posedge CLK) begin
    if (RST)           r_oor <= 1'b0;
    else if (w_out_we) r_oor <= w_oor;
  end
  assign out_of_range = r_oor;
`else
  logic w_unused_hi;
  assign w_unused_hi  = ^w_radius[15:9];
  assign w_dist       = w_radius[8:0];
  assign out_of_range = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_xmaj   <= 1'b0;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_sect   <= '0;
      r_cnt    <= '0;
      r_dist   <= '0;
      r_angle  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) begin
        r_a      <= w_xmaj ? w_adx : w_ady;
        r_b      <= w_xmaj ? w_ady : w_adx;
        r_xmaj   <= w_xmaj;
        r_dx_neg <= w_dx[10];
        r_dy_neg <= w_dy[10];
      end
      if (r_state == CLASS) begin
        r_sect <= w_angle;
        r_cnt  <= '0;
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_out_we) begin
        r_dist  <= w_dist;
        r_angle <= w_angle_out;
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign distance = r_dist;
  assign angle    = r_angle;

endmodule
